booth_divider: RTL

- Sequential signed integer divider. It is the inverse datapath of the team's Booth multiplier in the ALU.
- Takes a WIDTH-bit two's-complement dividend and divisor. Produces quotient and remainder using shift-subtract restoring division on magnitudes, one quotient bit per clock, followed by a sign-fix step.
- Sits beside the multiplier in the ALU execute path. Uses a start/busy/done handshake so the ALU controller can sequence it.

---
 rtl/booth_divider_if.sv | 23 ++
 rtl/booth_divider.sv | 120 ++++++++++++
 2 files changed

// File: rtl/booth_divider_if.sv
// rtl/booth_divider_if.sv - start/busy/done handshake bundle for the signed sequential divider
interface booth_divider_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_err;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_err
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_err
  );
endinterface

// File: rtl/booth_divider.sv
// rtl/booth_divider.sv - signed restoring divider, one quotient bit per clock, then sign fix
// Optional divide-by-zero short cut and flag: BOOTH_DIV_ZERO_DETECT_EN
module booth_divider #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic reset,
  booth_divider_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] q_reg, m_reg;
  logic [WIDTH:0]   r_reg;
  logic [CNT_W-1:0] cnt;
  logic             sign_q, sign_r;
  logic [WIDTH-1:0] quot_r, rem_r;
  logic             done_r;
  logic             zero_skip;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH+1:0] trial;
  logic             last_iter;

  assign a_neg = bus.dividend[WIDTH-1];
  assign b_neg = bus.divisor[WIDTH-1];
  assign abs_a = a_neg ? -bus.dividend : bus.dividend;
  assign abs_b = b_neg ? -bus.divisor : bus.divisor;

  // Shift {R,Q} left by one, then trial-subtract the divisor magnitude; the
  // extra top bit of trial is the borrow that decides the quotient bit.
  assign r_sh      = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
  assign trial     = {1'b0, r_sh} - {2'b00, m_reg};
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

`ifdef BOOTH_DIV_ZERO_DETECT_EN
  logic zero_r, err_r;
  assign zero_skip   = (bus.divisor == '0);
  assign bus.div_err = err_r;
`else
  assign zero_skip   = 1'b0;
  assign bus.div_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = zero_skip ? FIX : CALC;
      CALC:    if (last_iter) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg  <= '0;
      m_reg  <= '0;
      r_reg  <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      quot_r <= '0;
      rem_r  <= '0;
      done_r <= 1'b0;
`ifdef BOOTH_DIV_ZERO_DETECT_EN
      zero_r <= 1'b0;
      err_r  <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            // A zero divisor preloads the final magnitudes so FIX yields all-ones / dividend.
            q_reg  <= zero_skip ? '1 : abs_a;
            r_reg  <= zero_skip ? {1'b0, abs_a} : '0;
            m_reg  <= abs_b;
            cnt    <= '0;
            sign_q <= zero_skip ? 1'b0 : (a_neg ^ b_neg);
            sign_r <= a_neg;
`ifdef BOOTH_DIV_ZERO_DETECT_EN
            zero_r <= zero_skip;
`endif
          end
        end
        CALC: begin
          r_reg <= trial[WIDTH+1] ? r_sh : trial[WIDTH:0];
          q_reg <= {q_reg[WIDTH-2:0], ~trial[WIDTH+1]};
          cnt   <= cnt + 1'b1;
        end
        FIX: begin
          quot_r <= sign_q ? -q_reg : q_reg;
          rem_r  <= sign_r ? -r_reg[WIDTH-1:0] : r_reg[WIDTH-1:0];
          done_r <= 1'b1;
`ifdef BOOTH_DIV_ZERO_DETECT_EN
          err_r  <= zero_r;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_r;
  assign bus.quotient  = quot_r;
  assign bus.remainder = rem_r;
endmodule
